and_unit_arbiter: RTL



---
 rtl/and_unit_arbiter.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/and_unit_arbiter.sv
// ---------------------------------------------------------------------------
// and_unit_arbiter
//
// Purpose:
//   Round-robin arbiter and sequencer that time-shares a single registered
//   bitwise gate unit (c = a & b) among NUM_REQ requesters. The winner's
//   operands are latched in IDLE, the result is produced one clock later and
//   presented for exactly one cycle together with the winner's ID.
//
//   Sequence per transaction: IDLE -> EXEC -> DONE -> IDLE (3 clocks).
//
// Parameters:
//   NUM_REQ  number of requesters, 2..8
//   WIDTH    operand / result width in bits
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   req      request level per requester (bit i = requester i)
//   a_in     operand A, requester i owns [i*WIDTH +: WIDTH]
//   b_in     operand B, same slicing as a_in
//   op_in    (GATE_OPSEL_EN only) operator per requester, [2i +: 2]
//   gnt      one-hot grant, high during EXEC
//   busy     high whenever the sequencer is not in IDLE
//   c_out    result register (held until the next result)
//   c_op     (GATE_OPSEL_EN only) operator that produced c_out
//   c_valid  one-cycle result strobe
//   c_id     requester index owning c_out, zero-extended to 3 bits
//
// Optional feature:
//   GATE_OPSEL_EN  when defined, adds op_in/c_op and selects
//                  00=AND 01=OR 10=XOR 11=NAND. Undefined: AND only.
// ---------------------------------------------------------------------------
module and_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   a_in,
  input  logic [NUM_REQ*WIDTH-1:0]   b_in,
`ifdef GATE_OPSEL_EN
  input  logic [NUM_REQ*2-1:0]       op_in,
  output logic [1:0]                 c_op,
`endif
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic [WIDTH-1:0]           c_out,
  output logic                       c_valid,
  output logic [2:0]                 c_id
);

  // Index space is always 8 entries wide so a 3-bit index never exceeds the
  // table; entries at or above NUM_REQ read as zero.
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [2:0]          r_id;
  logic [2:0]          r_ptr;
  logic [WIDTH-1:0]    r_c;
  logic                r_valid;
  logic [2:0]          r_cid;
  logic [1:0]          r_op;
  logic [1:0]          r_cop;

  // -------------------------------------------------------------------------
  // Next-state wires
  // -------------------------------------------------------------------------
  state_t              w_state_next;
  logic [NUM_REQ-1:0]  w_gnt_next;
  logic [WIDTH-1:0]    w_a_next;
  logic [WIDTH-1:0]    w_b_next;
  logic [2:0]          w_id_next;
  logic [2:0]          w_ptr_next;
  logic [WIDTH-1:0]    w_c_next;
  logic                w_valid_next;
  logic [2:0]          w_cid_next;
  logic [1:0]          w_op_next;
  logic [1:0]          w_cop_next;

  // -------------------------------------------------------------------------
  // Unpack the flattened request-side buses into 8-entry tables
  // -------------------------------------------------------------------------
  logic [MAX_REQ-1:0]  w_req_ext;
  logic [WIDTH-1:0]    w_a_arr  [MAX_REQ];
  logic [WIDTH-1:0]    w_b_arr  [MAX_REQ];
  logic [1:0]          w_op_arr [MAX_REQ];

  assign w_req_ext = MAX_REQ'(req);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_live
        assign w_a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
        assign w_b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
`ifdef GATE_OPSEL_EN
        assign w_op_arr[gi] = op_in[gi*2 +: 2];
`else
        assign w_op_arr[gi] = 2'b00;
`endif
      end else begin : g_pad
        assign w_a_arr[gi]  = '0;
        assign w_b_arr[gi]  = '0;
        assign w_op_arr[gi] = 2'b00;
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin winner search: first set request at or after r_ptr,
  // wrapping modulo NUM_REQ. Scanning from the far end down lets the
  // nearest hit overwrite any farther one.
  // -------------------------------------------------------------------------
  logic        w_found;
  logic [2:0]  w_win;
  logic [3:0]  w_idx;

  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = 4'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = 4'(r_ptr) + 4'(k);
      if (w_idx >= 4'(NUM_REQ)) begin
        w_idx = w_idx - 4'(NUM_REQ);
      end
      if (w_req_ext[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[2:0];
      end
    end
  end

  // Pointer advance: one past the winner, wrapped.
  logic [3:0] w_id_inc;
  assign w_id_inc = 4'(r_id) + 4'd1;

  // -------------------------------------------------------------------------
  // Gate datapath on the latched operands
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] w_result;

  always_comb begin
    w_result = r_a & r_b;
    case (r_op)
      2'b01:   w_result = r_a | r_b;
      2'b10:   w_result = r_a ^ r_b;
      2'b11:   w_result = ~(r_a & r_b);
      default: w_result = r_a & r_b;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: next-state and register updates
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_id_next    = r_id;
    w_ptr_next   = r_ptr;
    w_c_next     = r_c;
    w_valid_next = 1'b0;
    w_cid_next   = r_cid;
    w_op_next    = r_op;
    w_cop_next   = r_cop;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_next   = NUM_REQ'(1) << w_win;
          w_a_next     = w_a_arr[w_win];
          w_b_next     = w_b_arr[w_win];
          w_op_next    = w_op_arr[w_win];
          w_id_next    = w_win;
          w_state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        w_c_next     = w_result;
        w_cop_next   = r_op;
        w_cid_next   = r_id;
        w_valid_next = 1'b1;
        w_gnt_next   = '0;
        w_ptr_next   = (w_id_inc >= 4'(NUM_REQ)) ? 3'd0 : w_id_inc[2:0];
        w_state_next = S_DONE;
      end

      S_DONE: begin
        // Requests are deliberately not looked at here; a level still high
        // next cycle is picked up by IDLE as a fresh request.
        w_state_next = S_IDLE;
      end

      default: begin
        w_gnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= 3'd0;
      r_ptr   <= 3'd0;
      r_c     <= '0;
      r_valid <= 1'b0;
      r_cid   <= 3'd0;
      r_op    <= 2'b00;
      r_cop   <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_id    <= w_id_next;
      r_ptr   <= w_ptr_next;
      r_c     <= w_c_next;
      r_valid <= w_valid_next;
      r_cid   <= w_cid_next;
      r_op    <= w_op_next;
      r_cop   <= w_cop_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign gnt     = r_gnt;
  assign busy    = (r_state != S_IDLE);
  assign c_out   = r_c;
  assign c_valid = r_valid;
  assign c_id    = r_cid;

`ifdef GATE_OPSEL_EN
  assign c_op = r_cop;
`else
  // Without operator select the operator register is constant AND.
  logic w_cop_unused;
  assign w_cop_unused = ^r_cop;
`endif

endmodule
